// File: rtl/sequenciador_faces.sv
// Six-face scan scheduler: capture -> identify -> rotate per face, each wait
// guarded by a timeout, with completion pulse and sticky error state.
module sequenciador_faces #(
  parameter int unsigned          N_FACES   = 6,
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       captura_pronto,
  input  logic       identifica_pronto,
  input  logic       gira_pronto,
  output logic       inicia_captura,
  output logic       inicia_identifica,
  output logic       inicia_gira,
  output logic [2:0] movimento,
  output logic [2:0] face,
  output logic       erro,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL            = 4'd0,
    DISPARA_CAPTURA    = 4'd1,
    ESPERA_CAPTURA     = 4'd2,
    DISPARA_IDENTIFICA = 4'd3,
    ESPERA_IDENTIFICA  = 4'd4,
    PROXIMA_FACE       = 4'd5,
    DISPARA_GIRO       = 4'd6,
    ESPERA_GIRO        = 4'd7,
    FIM                = 4'd8,
    ERRO               = 4'd9
  } estado_t;

  localparam logic [TIMEOUT_W-1:0] ULTIMO_TICK = TIMEOUT - 1'b1;
  localparam logic [2:0]           ULTIMA_FACE = 3'(N_FACES - 1);

  estado_t              estado;
  estado_t              proximo;
  logic [TIMEOUT_W-1:0] timer;
  logic [TIMEOUT_W-1:0] timer_next;
  logic [2:0]           face_next;
  logic                 expirou;

  assign expirou = (timer == ULTIMO_TICK);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values computed in the previous cycle, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      timer  <= '0;
      face   <= '0;
    end else begin
      estado <= proximo;
      timer  <= timer_next;
      face   <= face_next;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    proximo    = estado;
    timer_next = timer;
    face_next  = face;
    case (estado)
      INICIAL: begin
        if (iniciar) begin
          proximo   = DISPARA_CAPTURA;
          face_next = '0;
        end
      end
      DISPARA_CAPTURA: begin
        timer_next = '0;
        proximo    = ESPERA_CAPTURA;
      end
      ESPERA_CAPTURA: begin
        if (captura_pronto)  proximo    = DISPARA_IDENTIFICA;
        else if (expirou)    proximo    = ERRO;
        else                 timer_next = timer + 1'b1;
      end
      DISPARA_IDENTIFICA: begin
        timer_next = '0;
        proximo    = ESPERA_IDENTIFICA;
      end
      ESPERA_IDENTIFICA: begin
        if (identifica_pronto) proximo    = PROXIMA_FACE;
        else if (expirou)      proximo    = ERRO;
        else                   timer_next = timer + 1'b1;
      end
      PROXIMA_FACE: begin
        proximo = (face == ULTIMA_FACE) ? FIM : DISPARA_GIRO;
      end
      DISPARA_GIRO: begin
        timer_next = '0;
        proximo    = ESPERA_GIRO;
      end
      ESPERA_GIRO: begin
        // A done arriving on the last timer tick still wins over the timeout.
        if (gira_pronto) begin
          face_next = face + 3'd1;
          proximo   = DISPARA_CAPTURA;
        end else if (expirou) begin
          proximo = ERRO;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      FIM: begin
        proximo = INICIAL;
      end
      ERRO: begin
        if (iniciar) begin
          proximo   = DISPARA_CAPTURA;
          face_next = '0;
        end
      end
      default: begin
        proximo = INICIAL;
      end
    endcase
  end

  // Moore outputs: decoded only from registered state and face.
  always_comb begin
    inicia_captura    = (estado == DISPARA_CAPTURA);
    inicia_identifica = (estado == DISPARA_IDENTIFICA);
    inicia_gira       = (estado == DISPARA_GIRO);
    erro              = (estado == ERRO);
    pronto            = (estado == FIM);
    db_estado         = (estado > ERRO) ? 4'hF : 4'(estado);
    movimento         = 3'b000;
    if (estado == DISPARA_GIRO || estado == ESPERA_GIRO) begin
      case (face)
        3'd0, 3'd1, 3'd2: movimento = 3'b001;
        3'd3:             movimento = 3'b010;
        3'd4:             movimento = 3'b011;
        default:          movimento = 3'b000;
      endcase
    end
  end

  a_pulsos_exclusivos: assert property (@(posedge clock) disable iff (reset)
    $onehot0({inicia_captura, inicia_identifica, inicia_gira, pronto, erro}));

  a_face_valida: assert property (@(posedge clock) disable iff (reset)
    face <= ULTIMA_FACE);

  a_captura_um_ciclo: assert property (@(posedge clock) disable iff (reset)
    inicia_captura |=> !inicia_captura);

endmodule

// File: tb/tb_sequenciador_faces.sv
// Randomized bench for sequenciador_faces: responders with random latencies,
// timing/sequence expectations computed from per-face latency arithmetic.
module tb_sequenciador_faces;

  localparam int TMO    = 16;
  localparam int BUDGET = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       captura_pronto = 1'b0;
  logic       identifica_pronto = 1'b0;
  logic       gira_pronto = 1'b0;
  logic       inicia_captura, inicia_identifica, inicia_gira, erro, pronto;
  logic [2:0] movimento, face;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_cap = 0, n_ide = 0, n_gira = 0, n_pronto = 0, n_erro = 0;

  int dc[6], di[6], dg[5];
  int rec_ini, rec_pronto;
  int rec_cap[6], rec_face[6], rec_ide[6], rec_mov_cap[6];
  int rec_gira[5], rec_mov[5];
  int exp_cap[6], exp_ide[6], exp_gira[5], exp_pronto;
  int mov_table[5] = '{1, 1, 1, 2, 3};

  sequenciador_faces #(
    .N_FACES  (6),
    .TIMEOUT_W(24),
    .TIMEOUT  (24'(TMO))
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .captura_pronto   (captura_pronto),
    .identifica_pronto(identifica_pronto),
    .gira_pronto      (gira_pronto),
    .inicia_captura   (inicia_captura),
    .inicia_identifica(inicia_identifica),
    .inicia_gira      (inicia_gira),
    .movimento        (movimento),
    .face             (face),
    .erro             (erro),
    .pronto           (pronto),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (inicia_captura === 1'b1)    n_cap++;
    if (inicia_identifica === 1'b1) n_ide++;
    if (inicia_gira === 1'b1)       n_gira++;
    if (pronto === 1'b1)            n_pronto++;
    if (erro === 1'b1)              n_erro++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic sig_val(input int sig);
    case (sig)
      0:       return inicia_captura;
      1:       return inicia_identifica;
      2:       return inicia_gira;
      3:       return pronto;
      default: return erro;
    endcase
  endfunction

  // Checks the current negedge first, then steps; bounded by budget cycles.
  task automatic await(input int sig, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig_val(sig) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Done raised d cycles after the wait state is entered, for one cycle.
  task automatic respond(input int sig, input int d);
    repeat (d + 1) @(negedge clock);
    case (sig)
      0:       captura_pronto = 1'b1;
      1:       identifica_pronto = 1'b1;
      default: gira_pronto = 1'b1;
    endcase
    @(negedge clock);
    captura_pronto    = 1'b0;
    identifica_pronto = 1'b0;
    gira_pronto       = 1'b0;
  endtask

  task automatic start_pulse();
    iniciar = 1'b1;
    rec_ini = cyc;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic apply_reset();
    iniciar = 1'b0;
    captura_pronto = 1'b0;
    identifica_pronto = 1'b0;
    gira_pronto = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic random_delays(input int hi);
    for (int f = 0; f < 6; f++) begin
      dc[f] = $urandom_range(0, hi);
      di[f] = $urandom_range(0, hi);
      if (f < 5) dg[f] = $urandom_range(0, hi);
    end
  endtask

  // Drives a scan using dc/di/dg; stops right after the pulse of
  // (stop_face, stop_stage) when stop_face >= 0.
  task automatic run_scan(input int stop_face, input int stop_stage);
    bit seen;
    for (int f = 0; f < 6; f++) begin
      rec_cap[f] = -1; rec_face[f] = -1; rec_ide[f] = -1; rec_mov_cap[f] = -1;
      if (f < 5) begin rec_gira[f] = -1; rec_mov[f] = -1; end
    end
    rec_pronto = -1;
    start_pulse();
    for (int f = 0; f < 6; f++) begin
      await(0, BUDGET, seen);
      if (!seen) return;
      rec_cap[f] = cyc; rec_face[f] = int'(face); rec_mov_cap[f] = int'(movimento);
      if (stop_face == f && stop_stage == 0) return;
      respond(0, dc[f]);
      await(1, BUDGET, seen);
      if (!seen) return;
      rec_ide[f] = cyc;
      if (stop_face == f && stop_stage == 1) return;
      respond(1, di[f]);
      if (f < 5) begin
        await(2, BUDGET, seen);
        if (!seen) return;
        rec_gira[f] = cyc; rec_mov[f] = int'(movimento);
        if (stop_face == f && stop_stage == 2) return;
        respond(2, dg[f]);
      end
    end
    await(3, BUDGET, seen);
    if (seen) rec_pronto = cyc;
  endtask

  // Expected pulse cycles: capture +1 after iniciar; each wait lasts d+1
  // cycles; identify->rotate passes through the face-advance decision.
  function automatic void build_model();
    int t;
    t = rec_ini + 1;
    for (int f = 0; f < 6; f++) begin
      exp_cap[f] = t;
      t += 2 + dc[f];
      exp_ide[f] = t;
      t += 3 + di[f];
      if (f < 5) begin
        exp_gira[f] = t;
        t += 2 + dg[f];
      end else begin
        exp_pronto = t;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({inicia_captura, inicia_identifica, inicia_gira, erro, pronto} !== 5'b0) begin
        n_fail++; $display("FAIL reset_pulses[%0d]: got %b want 00000", k,
          {inicia_captura, inicia_identifica, inicia_gira, erro, pronto});
      end
      n_checks++;
      if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_db_estado[%0d]: got %0d want 0", k, db_estado); end
      n_checks++;
      if (face !== 3'd0) begin n_fail++; $display("FAIL reset_face[%0d]: got %0d want 0", k, face); end
      n_checks++;
      if (movimento !== 3'd0) begin n_fail++; $display("FAIL reset_movimento[%0d]: got %0d want 0", k, movimento); end
      reset = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_full_scan();
    int c0, i0, g0, p0, e0, total;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        for (int f = 0; f < 6; f++) begin dc[f] = 0; di[f] = 0; if (f < 5) dg[f] = 0; end
      end else begin
        random_delays(TMO - 1);
      end
      c0 = n_cap; i0 = n_ide; g0 = n_gira; p0 = n_pronto; e0 = n_erro;
      run_scan(-1, 0);
      build_model();
      total = 41;
      for (int f = 0; f < 6; f++) total += dc[f] + di[f] + ((f < 5) ? dg[f] : 0);
      for (int f = 0; f < 6; f++) begin
        n_checks++;
        if (rec_face[f] !== f) begin n_fail++; $display("FAIL scan%0d_face[%0d]: got %0d want %0d", it, f, rec_face[f], f); end
        n_checks++;
        if (rec_cap[f] !== exp_cap[f]) begin n_fail++; $display("FAIL scan%0d_cap_cycle[%0d]: got %0d want %0d", it, f, rec_cap[f], exp_cap[f]); end
        n_checks++;
        if (rec_ide[f] !== exp_ide[f]) begin n_fail++; $display("FAIL scan%0d_ide_cycle[%0d]: got %0d want %0d", it, f, rec_ide[f], exp_ide[f]); end
        n_checks++;
        if (rec_mov_cap[f] !== 0) begin n_fail++; $display("FAIL scan%0d_mov_idle[%0d]: got %0d want 0", it, f, rec_mov_cap[f]); end
      end
      for (int f = 0; f < 5; f++) begin
        n_checks++;
        if (rec_gira[f] !== exp_gira[f]) begin n_fail++; $display("FAIL scan%0d_gira_cycle[%0d]: got %0d want %0d", it, f, rec_gira[f], exp_gira[f]); end
        n_checks++;
        if (rec_mov[f] !== mov_table[f]) begin n_fail++; $display("FAIL scan%0d_movimento[%0d]: got %0d want %0d", it, f, rec_mov[f], mov_table[f]); end
      end
      n_checks++;
      if (rec_pronto !== exp_pronto) begin n_fail++; $display("FAIL scan%0d_pronto_cycle: got %0d want %0d", it, rec_pronto, exp_pronto); end
      n_checks++;
      if (rec_pronto - rec_cap[0] + 1 !== total) begin n_fail++; $display("FAIL scan%0d_length: got %0d want %0d", it, rec_pronto - rec_cap[0] + 1, total); end
      @(negedge clock);
      n_checks++;
      if (db_estado !== 4'd0 || pronto !== 1'b0) begin n_fail++; $display("FAIL scan%0d_back_to_inicial: got db=%0d pronto=%b want 0/0", it, db_estado, pronto); end
      n_checks++;
      if ({n_cap - c0, n_ide - i0, n_gira - g0, n_pronto - p0, n_erro - e0} !== {6, 6, 5, 1, 0}) begin
        n_fail++; $display("FAIL scan%0d_pulse_counts: got cap=%0d ide=%0d gira=%0d pronto=%0d erro=%0d want 6/6/5/1/0",
          it, n_cap - c0, n_ide - i0, n_gira - g0, n_pronto - p0, n_erro - e0);
      end
    end
  endtask

  task automatic test_min_latency();
    bit seen;
    int c0, first, span;
    c0 = n_cap;
    captura_pronto = 1'b1; identifica_pronto = 1'b1; gira_pronto = 1'b1;
    start_pulse();
    n_checks++;
    if (inicia_captura !== 1'b1) begin n_fail++; $display("FAIL minlat_start_pulse: got %b want 1", inicia_captura); end
    first = cyc;
    await(3, 100, seen);
    span = seen ? (cyc - first + 1) : -1;
    n_checks++;
    if (span !== 41) begin n_fail++; $display("FAIL minlat_span: got %0d want 41", span); end
    captura_pronto = 1'b0; identifica_pronto = 1'b0; gira_pronto = 1'b0;
    @(negedge clock);
    n_checks++;
    if (n_cap - c0 !== 6) begin n_fail++; $display("FAIL minlat_captures: got %0d want 6", n_cap - c0); end
    n_checks++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL minlat_end_state: got %0d want 0", db_estado); end
  endtask

  task automatic test_timeout();
    bit seen;
    int sf, ss, c, lat;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        sf = 0; ss = 0;
      end else begin
        sf = $urandom_range(0, 5);
        ss = (sf == 5) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      end
      random_delays(TMO - 1);
      run_scan(sf, ss);
      c = (ss == 0) ? rec_cap[sf] : (ss == 1) ? rec_ide[sf] : rec_gira[sf];
      await(4, BUDGET, seen);
      lat = (seen && c >= 0) ? (cyc - c) : -1;
      n_checks++;
      if (lat !== TMO + 1) begin n_fail++; $display("FAIL timeout%0d_latency(face %0d stage %0d): got %0d want %0d", it, sf, ss, lat, TMO + 1); end
      n_checks++;
      if (db_estado !== 4'd9) begin n_fail++; $display("FAIL timeout%0d_db_estado: got %0d want 9", it, db_estado); end
      n_checks++;
      if (face !== 3'(sf)) begin n_fail++; $display("FAIL timeout%0d_face: got %0d want %0d", it, face, sf); end
      captura_pronto = 1'b1; identifica_pronto = 1'b1; gira_pronto = 1'b1;
      repeat (3) @(negedge clock);
      captura_pronto = 1'b0; identifica_pronto = 1'b0; gira_pronto = 1'b0;
      n_checks++;
      if (erro !== 1'b1 || face !== 3'(sf)) begin n_fail++; $display("FAIL timeout%0d_sticky: got erro=%b face=%0d want 1/%0d", it, erro, face, sf); end
      start_pulse();
      n_checks++;
      if ({inicia_captura, erro, face} !== {1'b1, 1'b0, 3'd0}) begin
        n_fail++; $display("FAIL timeout%0d_restart: got cap=%b erro=%b face=%0d want 1/0/0", it, inicia_captura, erro, face);
      end
      apply_reset();
    end
  endtask

  task automatic test_boundary();
    int e0;
    for (int f = 0; f < 6; f++) begin dc[f] = 0; di[f] = 0; if (f < 5) dg[f] = 0; end
    dg[2] = TMO - 1;
    e0 = n_erro;
    run_scan(-1, 0);
    build_model();
    @(negedge clock);
    n_checks++;
    if (n_erro - e0 !== 0) begin n_fail++; $display("FAIL boundary_erro_cycles: got %0d want 0", n_erro - e0); end
    n_checks++;
    if (rec_face[3] !== 3) begin n_fail++; $display("FAIL boundary_face: got %0d want 3", rec_face[3]); end
    n_checks++;
    if (rec_cap[3] - rec_gira[2] !== TMO + 1) begin n_fail++; $display("FAIL boundary_next_capture: got %0d want %0d", rec_cap[3] - rec_gira[2], TMO + 1); end
    n_checks++;
    if (rec_pronto !== exp_pronto) begin n_fail++; $display("FAIL boundary_pronto_cycle: got %0d want %0d", rec_pronto, exp_pronto); end
  endtask

  task automatic test_reset_mid_run();
    random_delays(3);
    run_scan(3, 1);
    @(negedge clock);
    n_checks++;
    if (db_estado !== 4'd4 || face !== 3'd3) begin n_fail++; $display("FAIL midreset_pre: got db=%0d face=%0d want 4/3", db_estado, face); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({db_estado, face, movimento, inicia_captura, inicia_identifica, inicia_gira, erro, pronto} !== 15'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got db=%0d face=%0d mov=%0d pulses=%b want all 0", db_estado, face, movimento,
        {inicia_captura, inicia_identifica, inicia_gira, erro, pronto});
    end
    reset = 1'b0;
    @(negedge clock);
    random_delays(4);
    run_scan(-1, 0);
    build_model();
    for (int f = 0; f < 6; f++) begin
      n_checks++;
      if (rec_face[f] !== f) begin n_fail++; $display("FAIL midreset_rescan_face[%0d]: got %0d want %0d", f, rec_face[f], f); end
    end
    n_checks++;
    if (rec_pronto !== exp_pronto) begin n_fail++; $display("FAIL midreset_rescan_pronto: got %0d want %0d", rec_pronto, exp_pronto); end
    @(negedge clock);
  endtask

  task automatic test_spurious();
    int c0, i0;
    for (int f = 0; f < 6; f++) begin dc[f] = 0; di[f] = 0; if (f < 5) dg[f] = 0; end
    run_scan(1, 2);
    @(negedge clock);
    c0 = n_cap;
    n_checks++;
    if (db_estado !== 4'd7) begin n_fail++; $display("FAIL spurious_in_giro: got db=%0d want 7", db_estado); end
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    n_checks++;
    if ({db_estado, face, inicia_captura} !== {4'd7, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL spurious_iniciar: got db=%0d face=%0d cap=%b want 7/1/0", db_estado, face, inicia_captura);
    end
    gira_pronto = 1'b1;
    @(negedge clock);
    gira_pronto = 1'b0;
    n_checks++;
    if ({inicia_captura, face} !== {1'b1, 3'd2} || n_cap - c0 !== 0) begin
      n_fail++; $display("FAIL spurious_advance: got cap=%b face=%0d extra=%0d want 1/2/0", inicia_captura, face, n_cap - c0);
    end
    @(negedge clock);
    i0 = n_ide;
    identifica_pronto = 1'b1;
    @(negedge clock);
    identifica_pronto = 1'b0;
    n_checks++;
    if ({db_estado, inicia_identifica} !== {4'd2, 1'b0}) begin
      n_fail++; $display("FAIL spurious_identifica: got db=%0d ide=%b want 2/0", db_estado, inicia_identifica);
    end
    @(negedge clock);
    n_checks++;
    if (n_ide - i0 !== 0 || db_estado !== 4'd2) begin n_fail++; $display("FAIL spurious_hold: got extra=%0d db=%0d want 0/2", n_ide - i0, db_estado); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_min_latency();
    test_timeout();
    test_boundary();
    test_reset_mid_run();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_faces.md
# sequenciador_faces

Top-level scan scheduler for the cube-reading pipeline. It runs a six-face scan in a fixed order. For each face it triggers the OV7670 capture interface, then the colour-identification unit, then the cube-rotation mechanism, and it advances the face index used as the base address of the colour memory. Each wait is guarded by a timeout. The block reports completion or error to the system controller.

## Interface
Parameters:
- N_FACES, 6: number of faces scanned.
- TIMEOUT_W, 24: width of the wait-timer.
- TIMEOUT, 24'd10_000_000: cycles allowed in any wait state before error.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock; forces `inicial`.
- iniciar  in  1  start request; sampled only in `inicial` and `erro`.
- captura_pronto  in  1  capture interface finished the frame.
- identifica_pronto  in  1  colour-identification unit finished the 3x3 grid.
- gira_pronto  in  1  rotation mechanism finished the move.
- inicia_captura  out  1  one-cycle start pulse to the capture interface.
- inicia_identifica  out  1  one-cycle start pulse to the identification unit.
- inicia_gira  out  1  one-cycle start pulse to the mechanism.
- movimento  out  3  rotation code, valid in `dispara_giro`/`espera_giro`, else 0.
- face  out  3  current face index, 0..N_FACES-1.
- erro  out  1  high while in `erro`.
- pronto  out  1  one-cycle pulse when the scan completes.
- db_estado  out  4  state code, for debug displays.

## Operation
States and their db_estado codes:
- `inicial` (0): iniciar=1 -> `dispara_captura`; face<=0.
- `dispara_captura` (1): inicia_captura=1; timer<=0; -> `espera_captura`.
- `espera_captura` (2): captura_pronto -> `dispara_identifica`; else if timer==TIMEOUT-1 -> `erro`; else timer++.
- `dispara_identifica` (3): inicia_identifica=1; timer<=0; -> `espera_identifica`.
- `espera_identifica` (4): identifica_pronto -> `proxima_face`; timeout rule as above.
- `proxima_face` (5): face==N_FACES-1 -> `fim`; else -> `dispara_giro`.
- `dispara_giro` (6): inicia_gira=1; timer<=0; -> `espera_giro`.
- `espera_giro` (7): gira_pronto -> face<=face+1 and go to `dispara_captura`; timeout rule as above.
- `fim` (8): pronto=1 -> `inicial`.
- `erro` (9): erro=1; face holds the failing face; iniciar -> `dispara_captura` with face<=0.
- Unused codes -> `inicial`, with db_estado=4'hF for one cycle.

Movimento table, indexed by face during the giro states:
- 0, 1, 2 -> 3'b001 (X +90°).
- 3 -> 3'b010 (Y +90°).
- 4 -> 3'b011 (Y 180°).
- Codes are unsigned.

Timer:
- Unsigned, TIMEOUT_W bits, saturating never required: the compare fires first.

Priority and ignored inputs:
- A done input in the same cycle as timer==TIMEOUT-1: done wins, no error.
- iniciar is ignored in all states except `inicial` and `erro`.
- Done inputs are ignored outside their own wait state.

## Timing
- Reset values: state `inicial`, face=0, timer=0, movimento=0, all pulses 0, erro=0, pronto=0, db_estado=0.
- Outputs are decoded from the registered state: Moore, with no combinational path from inputs.
- Latency from start: iniciar sampled at edge k -> inicia_captura high during cycle k+1 (exactly one cycle).
- Latency from done: done sampled at edge k -> next start pulse (or `proxima_face`) in cycle k+1.
- Minimum per face with immediate done responses:
  - Faces 0-4: 7 cycles.
  - Last face: 5 cycles plus 1 cycle in `fim`.
- Minimum full scan: 5×7 + 5 + 1 = 41 cycles from the first inicia_captura to pronto inclusive.
- Timeout: entering the wait state at edge k with no done -> `erro` at edge k+TIMEOUT.
- Reset mid-operation: next edge returns to `inicial` with all reset values. Pulses already issued are not retracted; peer units are reset by the same line.
- face changes only at the `espera_giro` exit and on start/restart; stable otherwise.

## Test plan
- Full scan with TIMEOUT=16: each done returned 1 cycle after its start pulse. Required: 6 inicia_captura, 6 inicia_identifica, 5 inicia_gira, movimento sequence 1,1,1,2,3, face 0..5, one pronto, then `inicial`.
- Timeout: TIMEOUT=16, captura_pronto held 0 on face 0. Required: erro=1 and db_estado=9 exactly 16 cycles after entering `espera_captura`, face=0. iniciar then restarts: inicia_captura the next cycle.
- Boundary: gira_pronto asserted exactly at timer==15 (TIMEOUT=16) on face 2. Required: no erro, face becomes 3, inicia_captura the next cycle.
- Reset mid-run: reset during `espera_identifica` of face 3. Required: next cycle state 0, face=0, all outputs 0. A following iniciar starts from face 0.
- Spurious inputs: iniciar pulsed while in `espera_giro`, and identifica_pronto pulsed in `espera_captura`. Required: no state change and no extra start pulses.
- Minimum-latency check: all dones tied high. Required: pronto exactly 41 cycles after the first inicia_captura (inclusive count).
